// File: rtl/seg_debug_display_if.sv
// Bundle of probe inputs, display controls and display outputs for the
// debug display. The display drives the outputs (slave side); the board
// top level or a bench drives the probe words and controls (master side).
interface seg_debug_display_if #(
    parameter int N_CH   = 4,
    parameter int DIGITS = 8
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [32*N_CH-1:0] i_data;
    logic               i_next;
    logic               i_auto;
    logic               i_freeze;
    logic               i_blank_lz;
    logic [7:0]         o_seg;
    logic [DIGITS-1:0]  o_sel;
    logic [CW-1:0]      o_ch;

    modport master (
        output i_data, i_next, i_auto, i_freeze, i_blank_lz,
        input  o_seg, o_sel, o_ch
    );

    modport slave (
        input  i_data, i_next, i_auto, i_freeze, i_blank_lz,
        output o_seg, o_sel, o_ch
    );
endinterface

// File: rtl/seg_debug_display.sv
// Debug display: selects one of N_CH 32-bit probe words and scans its low
// DIGITS nibbles onto a multiplexed active-low 7-segment display. Channel
// stepping comes from a debounced push-button and an optional auto-rotate
// timer; the display can be frozen, leading zeros blanked, and the decimal
// point of digit <ch> marks the current channel.
module seg_debug_display #(
    parameter int N_CH        = 4,
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int AUTO_PERIOD = 100000000
) (
    input  logic               clk_in,
    input  logic               reset,
    seg_debug_display_if.slave bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam int NW = 4 * DIGITS;

    localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    // Hex digit to {dp,g,f,e,d,c,b,a} pattern, active-low, dp off.
    function automatic logic [7:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: hex_pat = 8'hC0;
            4'h1: hex_pat = 8'hF9;
            4'h2: hex_pat = 8'hA4;
            4'h3: hex_pat = 8'hB0;
            4'h4: hex_pat = 8'h99;
            4'h5: hex_pat = 8'h92;
            4'h6: hex_pat = 8'h82;
            4'h7: hex_pat = 8'hF8;
            4'h8: hex_pat = 8'h80;
            4'h9: hex_pat = 8'h90;
            4'hA: hex_pat = 8'h88;
            4'hB: hex_pat = 8'h83;
            4'hC: hex_pat = 8'hC6;
            4'hD: hex_pat = 8'hA1;
            4'hE: hex_pat = 8'h86;
            default: hex_pat = 8'h8E;
        endcase
    endfunction

    // Button path
    logic              sync1_q, sync2_q;
    logic              stable_q, stable_d;
    logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
    logic              deb_q, deb_d, deb_prev_q;
    logic              btn_pulse;

    // Channel stepping
    logic [AW-1:0]     auto_cnt_q, auto_cnt_d;
    logic              auto_tick;
    logic              step;
    logic [CW-1:0]     ch_q, ch_d;
    logic              ch_chg_q;

    // Scan and display
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              scan_tick, frame_tick;
    logic [31:0]       sel_word;
    logic [NW-1:0]     disp_q, disp_d;
    logic [DIGITS-1:0] upper_zero;
    logic [3:0]        cur_nib;
    logic              marker;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    // Two-flop synchroniser, debounce filter and edge-detect history.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            stable_q   <= 1'b0;
            deb_cnt_q  <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= bus.i_next;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // Restart the stability count on any change; accept the level once it has held long enough.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        deb_d     = deb_q;
        if (sync2_q != stable_q) begin
            stable_d  = sync2_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d = stable_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    assign btn_pulse  = deb_q & ~deb_prev_q;
    assign auto_tick  = bus.i_auto && (auto_cnt_q == AUTO_LAST);
    assign step       = btn_pulse | auto_tick;
    assign scan_tick  = (scan_cnt_q == SCAN_LAST);
    assign frame_tick = scan_tick && (idx_q == IDX_LAST);
    assign sel_word   = bus.i_data[32*ch_q +: 32];
    assign cur_nib    = disp_q[4*idx_q +: 4];
    assign marker     = (32'(idx_q) == 32'(ch_q));

    // Next state for auto timer, channel, scan position and display register.
    always_comb begin
        auto_cnt_d = auto_cnt_q + AW'(1);
        if (!bus.i_auto || btn_pulse || auto_tick) begin
            auto_cnt_d = '0;
        end

        ch_d = ch_q;
        if (step) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
        end

        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        // A channel change is picked up the cycle after ch_q moves, so the new word is selected.
        disp_d = disp_q;
        if (!bus.i_freeze && (ch_chg_q || frame_tick)) begin
            disp_d = sel_word[NW-1:0];
        end
    end

    // Channel, timer, scan and display-register state.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            auto_cnt_q <= '0;
            ch_q       <= '0;
            ch_chg_q   <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
            ch_q       <= ch_d;
            ch_chg_q   <= step;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
        end
    end

    // upper_zero[i] is set when nibbles i..DIGITS-1 of the shown word are all zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run && (disp_q[4*i +: 4] == 4'h0);
            upper_zero[i] = run;
        end
    end

    // Compose the next digit enable and segment pattern on each scan tick.
    always_comb begin
        seg_d = seg_q;
        sel_d = sel_q;
        if (scan_tick) begin
            sel_d = ~(DIGITS'(1) << idx_q);
            if (bus.i_blank_lz && (idx_q != '0) && upper_zero[idx_q]) begin
                seg_d = 8'hFF;
            end else begin
                seg_d = hex_pat(cur_nib);
            end
            // The channel marker stays visible even on a blanked digit.
            seg_d[7] = ~marker;
        end
    end

    // Output registers; blank until the first scan tick after reset.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            seg_q <= 8'hFF;
            sel_q <= '1;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign bus.o_seg = seg_q;
    assign bus.o_sel = sel_q;
    assign bus.o_ch  = ch_q;
endmodule

// File: tb/tb_seg_debug_display.sv
// Bench for seg_debug_display: directed stimulus, expected digits queued by
// the driver and consumed by a monitor each time a new digit is presented.
module tb_seg_debug_display;
    localparam int N_CH        = 4;
    localparam int DIGITS      = 8;
    localparam int SCAN_DIV    = 4;
    localparam int DEB_CYCLES  = 3;
    localparam int AUTO_PERIOD = 64;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   lat      = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  segs[8];

    seg_debug_display_if #(.N_CH(N_CH), .DIGITS(DIGITS)) bus ();

    seg_debug_display #(
        .N_CH(N_CH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES), .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk_in(clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Queue one frame of expected digits; f[d] is the segment byte for digit d.
    task automatic push_frame(input string nm, input logic [7:0] f[8]);
        logic [7:0] s;
        for (int d = 0; d < 8; d++) begin
            s = ~(8'h01 << d);
            exp_q.push_back({s, f[d]});
            name_q.push_back($sformatf("%s d%0d", nm, d));
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected digits never appeared", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Returns just after the last digit of a frame has been presented.
    task automatic wait_frame_end(input string nm);
        logic [7:0] prev;
        int         n;
        bit         seen;
        prev = bus.o_sel;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.o_sel != prev && bus.o_sel == 8'h7F) seen = 1'b1;
            prev = bus.o_sel;
        end
        #1;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: frame end got none expected o_sel=7f", nm);
        end
    endtask

    task automatic wait_ch_change(input string nm, input int max_cyc, output int at);
        logic [1:0] old;
        int         n;
        old = bus.o_ch;
        n   = 0;
        at  = -1;
        while (bus.o_ch == old && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_ch == old) begin
            checks++;
            failures++;
            $display("FAIL %s: o_ch stuck at %0d expected a change within %0d cycles", nm, old, max_cyc);
        end else begin
            at = cyc;
        end
    endtask

    task automatic wait_sel_change(output int at, output int idx);
        logic [7:0] prev;
        int         n;
        prev = bus.o_sel;
        n    = 0;
        at   = -1;
        idx  = 0;
        while (bus.o_sel == prev && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.o_sel == prev) begin
            failures++;
            $display("FAIL sel_change: o_sel stuck at %h expected a new digit", prev);
        end else begin
            at = cyc;
            for (int i = 0; i < 8; i++) if (!bus.o_sel[i]) idx = i;
        end
    endtask

    task automatic press();
        bus.i_next = 1'b1;
        repeat (8) @(negedge clk);
        bus.i_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: one expected entry per newly presented digit.
    initial begin
        logic [DIGITS-1:0] last_sel;
        logic [15:0]       e;
        string             nm;
        last_sel = '1;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_sel != last_sel && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, " sel"}, 32'(bus.o_sel), 32'(e[15:8]));
                check({nm, " seg"}, 32'(bus.o_seg), 32'(e[7:0]));
            end
            last_sel = bus.o_sel;
        end
    end

    // Driver
    initial begin
        int t0, at, at2, idx, p;
        logic [7:0] ch1_segs[8];
        logic [7:0] want;

        rst_n          = 1'b0;
        bus.i_data     = '0;
        bus.i_next     = 1'b0;
        bus.i_auto     = 1'b0;
        bus.i_freeze   = 1'b0;
        bus.i_blank_lz = 1'b0;
        bus.i_data[31:0]   = 32'h1234_ABCD;
        bus.i_data[63:32]  = 32'h5566_7788;
        bus.i_data[95:64]  = 32'h9ABC_DEF0;
        bus.i_data[127:96] = 32'h0F1E_2D3C;
        ch1_segs = '{8'h80, 8'h80, 8'hF8, 8'hF8, 8'h82, 8'h82, 8'h92, 8'h92};

        // 1: reset state, first frame shows the cleared register, then ch0
        repeat (3) @(negedge clk);
        check("reset o_seg", 32'(bus.o_seg), 32'h0FF);
        check("reset o_sel", 32'(bus.o_sel), 32'h0FF);
        check("reset o_ch",  32'(bus.o_ch),  32'd0);
        rst_n = 1'b1;
        segs = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        push_frame("t1 cleared", segs);
        segs = '{8'h21, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        push_frame("t1 ch0", segs);
        wait_drain("t1 frames");

        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset o_seg", 32'(bus.o_seg), 32'h0FF);
        check("midreset o_sel", 32'(bus.o_sel), 32'h0FF);
        @(negedge clk);
        rst_n = 1'b1;
        segs = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        push_frame("t1 after reset", segs);
        wait_drain("t1 after reset");

        // 2: debounce
        bus.i_next = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_next = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch o_ch", 32'(bus.o_ch), 32'd0);

        p = cyc;
        bus.i_next = 1'b1;
        wait_ch_change("held press", 30, at);
        lat = at - p;
        check("held o_ch", 32'(bus.o_ch), 32'd1);
        wait_sel_change(at2, idx);
        if (at2 - at <= 1) wait_sel_change(at2, idx);
        want = ch1_segs[idx];
        if (idx == 1) want[7] = 1'b0;
        check("ch1 next digit seg", 32'(bus.o_seg), 32'(want));
        bus.i_next = 1'b0;
        repeat (20) @(negedge clk);
        check("held single step", 32'(bus.o_ch), 32'd1);

        press();
        check("press2 o_ch", 32'(bus.o_ch), 32'd2);
        press();
        check("press3 o_ch", 32'(bus.o_ch), 32'd3);
        press();
        check("press4 wrap o_ch", 32'(bus.o_ch), 32'd0);

        // 3: auto-rotate
        t0 = cyc;
        bus.i_auto = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_ch_change("auto", 80, at);
            check($sformatf("auto step%0d time", k), 32'(at - t0), 32'(64 * k));
            check($sformatf("auto step%0d o_ch", k), 32'(bus.o_ch), 32'(k % 4));
        end
        wait_until(t0 + 320 - lat);
        bus.i_next = 1'b1;
        wait_ch_change("pulse on tick", 20, at);
        check("pulse on tick time", 32'(at - t0), 32'd320);
        check("pulse on tick o_ch", 32'(bus.o_ch), 32'd1);
        repeat (3) @(negedge clk);
        bus.i_next = 1'b0;
        wait_ch_change("auto after coincide", 80, at);
        check("auto after coincide time", 32'(at - t0), 32'd384);
        check("auto after coincide o_ch", 32'(bus.o_ch), 32'd2);
        wait_until(t0 + 404 - lat);
        bus.i_next = 1'b1;
        wait_ch_change("mid press", 20, at);
        check("mid press time", 32'(at - t0), 32'd404);
        check("mid press o_ch", 32'(bus.o_ch), 32'd3);
        repeat (3) @(negedge clk);
        bus.i_next = 1'b0;
        wait_ch_change("timer restart", 100, at);
        check("timer restart time", 32'(at - t0), 32'd468);
        check("timer restart o_ch", 32'(bus.o_ch), 32'd0);
        bus.i_auto = 1'b0;

        // 4: leading-zero blanking
        bus.i_blank_lz   = 1'b1;
        bus.i_data[31:0] = 32'h0000_00A5;
        wait_frame_end("t4 a5 sync");
        segs = '{8'h12, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push_frame("t4 a5", segs);
        wait_drain("t4 a5");
        bus.i_data[31:0] = 32'h0;
        wait_frame_end("t4 zero sync");
        segs = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push_frame("t4 zero", segs);
        wait_drain("t4 zero");

        // 5: freeze
        bus.i_freeze     = 1'b1;
        bus.i_data[31:0] = 32'hCAFE_F00D;
        press();
        check("frozen o_ch", 32'(bus.o_ch), 32'd1);
        wait_frame_end("t5 frozen sync");
        segs = '{8'hC0, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push_frame("t5 frozen", segs);
        wait_drain("t5 frozen");
        wait_frame_end("t5 unfreeze sync");
        bus.i_freeze   = 1'b0;
        bus.i_blank_lz = 1'b0;
        segs = '{8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        push_frame("t5 old", segs);
        segs = '{8'h80, 8'h00, 8'hF8, 8'hF8, 8'h82, 8'h82, 8'h92, 8'h92};
        push_frame("t5 ch1", segs);
        wait_drain("t5 unfrozen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
